// File: rtl/tx_mode_select.sv
// tx_mode_select
//   Produces the UART TX mode bit (cntmodetx: 0 = CS, 1 = FF) for the TX-mode
//   7-segment decoder. The raw active-low push button is synchronised and
//   debounced, and every debounced press toggles the mode.
//
//   Build option TXMODE_BUSY_DEFER_EN:
//     defined   - a press seen while tx_busy is high is queued in a PENDING
//                 state and applied when tx_busy drops. At most one toggle is
//                 queued, so the mode never changes under an in-flight frame.
//     undefined - tx_busy is ignored and every press toggles on the next edge.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   key_n        in   raw push button, active-low, asynchronous to clk
//   tx_busy      in   high while a UART frame is in flight (level, not a handshake)
//   cntmodetx    out  registered TX mode, 0 = CS, 1 = FF
//   mode_changed out  one-cycle pulse in the cycle cntmodetx takes its new value
//
// Parameters
//   DB_CYCLES    debounce window in clk cycles (>= 2)
//   CNT_W        debounce counter width, derived from DB_CYCLES

module tx_mode_select #(
    parameter  int DB_CYCLES = 1_000_000,
    localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic tx_busy,
    output logic cntmodetx,
    output logic mode_changed
);

    logic [1:0]       sync_ff;
    logic             key_s;
    logic             key_stable;
    logic [CNT_W-1:0] db_cnt;
    logic             db_done;
    logic             press_evt;
    logic             toggle;

    // Two-flop synchroniser; the only place key_n is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], key_n};
        end
    end

    assign key_s = sync_ff[1];

    // A difference that has persisted for DB_CYCLES cycles is accepted.
    // db_cnt tops out at DB_CYCLES-1, so it cannot wrap.
    assign db_done = (key_s != key_stable) && (db_cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_stable <= 1'b1;
            db_cnt     <= '0;
            press_evt  <= 1'b0;
        end else begin
            // Only a 1->0 commit of the stable level is a press; releases are silent.
            press_evt <= db_done && !key_s;
            if (key_s == key_stable) begin
                db_cnt <= '0;
            end else if (db_done) begin
                key_stable <= key_s;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TXMODE_BUSY_DEFER_EN
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Presses arriving while PENDING are dropped: one queued toggle at most.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press_evt && tx_busy) state_nxt = PENDING;
            PENDING: if (!tx_busy)             state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // A press in the same cycle tx_busy is low toggles at once.
    always_comb begin
        toggle = 1'b0;
        case (state)
            IDLE:    toggle = press_evt && !tx_busy;
            PENDING: toggle = !tx_busy;
            default: toggle = 1'b0;
        endcase
    end
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign toggle         = press_evt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntmodetx    <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= toggle;
            if (toggle) begin
                cntmodetx <= ~cntmodetx;
            end
        end
    end

endmodule

// File: tb/tb_tx_mode_select.sv
module tb_tx_mode_select;

    localparam int DB     = 8;
    localparam int LAT_LO = DB + 3;
    localparam int LAT_HI = DB + 4;

    logic clk;
    logic rst;
    logic key_n;
    logic tx_busy;
    logic cntmodetx;
    logic mode_changed;

    tx_mode_select #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .tx_busy      (tx_busy),
        .cntmodetx    (cntmodetx),
        .mode_changed (mode_changed)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d required < 50000", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    logic       model_mode = 1'b0;
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         n_pulses   = 0;
    int         fall_cyc   = 0;
    bit         lat_armed  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Every mode_changed pulse must match the oldest expected mode value.
    always @(negedge clk) begin
        if (!rst && mode_changed) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got pulse with mode %0d required no pulse (cycle %0d)",
                         cntmodetx, cyc);
            end else begin
                check("pulse_mode", int'(cntmodetx), int'(exp_q.pop_front()));
            end
            if (lat_armed) begin
                lat_armed = 1'b0;
                n_checks++;
                if (cyc - fall_cyc >= LAT_LO && cyc - fall_cyc <= LAT_HI) n_pass++;
                else $display("FAIL latency: got %0d clks required %0d..%0d",
                              cyc - fall_cyc, LAT_LO, LAT_HI);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        model_mode = 1'b0;
        exp_q.delete();
        lat_armed  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Hold key low for low_len clocks, then release and wait for the release
    // to debounce before returning.
    task automatic press(input int low_len, input bit expect_toggle, input bit timed);
        @(negedge clk);
        key_n = 1'b0;
        if (expect_toggle) begin
            model_mode = ~model_mode;
            exp_q.push_back(model_mode);
            if (timed) begin
                fall_cyc  = cyc;
                lat_armed = 1'b1;
            end
        end
        repeat (low_len) @(negedge clk);
        key_n = 1'b1;
        repeat ($urandom_range(20, 30)) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        lat_armed = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int low_len;
        int reps;
        bit expect_toggle;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p0;
        int rlen;

        vecs[0] = '{20, 1, 1'b1};   // clean long press
        vecs[1] = '{5,  3, 1'b0};   // glitches shorter than window
        vecs[2] = '{12, 1, 1'b1};
        vecs[3] = '{DB - 1, 1, 1'b0}; // one clock short of window
        vecs[4] = '{DB, 1, 1'b1};   // exactly the window
        vecs[5] = '{3,  2, 1'b0};
        vecs[6] = '{30, 1, 1'b1};
        rlen    = $urandom_range(1, 25);
        vecs[7] = '{rlen, 1, (rlen >= DB)};

        // reset state
        rst     = 1'b1;
        key_n   = 1'b1;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mode_during", int'(cntmodetx), 0);
        check("reset_pulse_during", int'(mode_changed), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mode_after", int'(cntmodetx), 0);
        check("reset_pulse_after", int'(mode_changed), 0);

        // table-driven presses with tx_busy low
        for (int i = 0; i < 8; i++) begin
            p0 = n_pulses;
            for (int r = 0; r < vecs[i].reps; r++)
                press(vecs[i].low_len, vecs[i].expect_toggle, 1'b1);
            check($sformatf("vec%0d_mode", i), int'(cntmodetx), int'(model_mode));
            check($sformatf("vec%0d_pulses", i), n_pulses - p0,
                  vecs[i].expect_toggle ? vecs[i].reps : 0);
            drain_check($sformatf("vec%0d_drain", i));
        end

        // two presses while tx_busy is high
        do_reset();
        p0      = n_pulses;
        tx_busy = 1'b1;
`ifdef TXMODE_BUSY_DEFER_EN
        press(20, 1'b0, 1'b0);
        press(20, 1'b0, 1'b0);
        check("busy_hold_mode", int'(cntmodetx), 0);
        check("busy_hold_pulses", n_pulses - p0, 0);
        @(negedge clk);
        tx_busy    = 1'b0;
        model_mode = ~model_mode;
        exp_q.push_back(model_mode);
        @(negedge clk);
        check("defer_release_mode", int'(cntmodetx), 1);
        check("defer_release_pulse", int'(mode_changed), 1);
        repeat (10) @(negedge clk);
        check("defer_pulses", n_pulses - p0, 1);
        drain_check("defer_drain");

        // reset while a toggle is queued discards it
        do_reset();
        p0      = n_pulses;
        tx_busy = 1'b1;
        press(20, 1'b0, 1'b0);
        check("pending_mode", int'(cntmodetx), 0);
        do_reset();
        tx_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("pending_reset_mode", int'(cntmodetx), 0);
        check("pending_reset_pulses", n_pulses - p0, 0);
        drain_check("pending_reset_drain");
`else
        press(20, 1'b1, 1'b1);
        check("busy_ignored_first", int'(cntmodetx), 1);
        press(20, 1'b1, 1'b1);
        check("busy_ignored_second", int'(cntmodetx), 0);
        check("busy_ignored_pulses", n_pulses - p0, 2);
        tx_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_drop_mode", int'(cntmodetx), 0);
        check("busy_drop_pulses", n_pulses - p0, 2);
        drain_check("busy_ignored_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
